// File: rtl/alu_unit.sv
// alu_unit: two-stage integer ALU / branch-resolution unit for the OoO core.
//   S1 latches a dispatched op from the reservation station. S2 registers the
//   computed result, the jump decision and the redirect target, then
//   broadcasts them with the ROB tag.
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (0 = freeze), clr_in (flush)
//   rs_to_alu_*     : dispatch bundle (valid, op, rs1, rs2, imm, PC, rob tag)
//   alu_ready       : broadcast valid; qualifies every other alu_* output
//   alu_result      : destination value
//   alu_rob_index   : ROB tag of the broadcast
//   alu_jump        : control transfer taken
//   alu_target_PC   : next PC of the instruction

package alu_unit_pkg;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ROB_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 6'd0,
    OP_ADD   = 6'd1,  OP_SUB   = 6'd2,  OP_AND   = 6'd3,  OP_OR    = 6'd4,
    OP_XOR   = 6'd5,  OP_SLL   = 6'd6,  OP_SRL   = 6'd7,  OP_SRA   = 6'd8,
    OP_SLT   = 6'd9,  OP_SLTU  = 6'd10,
    OP_ADDI  = 6'd11, OP_ANDI  = 6'd12, OP_ORI   = 6'd13, OP_XORI  = 6'd14,
    OP_SLLI  = 6'd15, OP_SRLI  = 6'd16, OP_SRAI  = 6'd17, OP_SLTI  = 6'd18,
    OP_SLTIU = 6'd19,
    OP_LUI   = 6'd20, OP_AUIPC = 6'd21, OP_JAL   = 6'd22, OP_JALR  = 6'd23,
    OP_BEQ   = 6'd24, OP_BNE   = 6'd25, OP_BLT   = 6'd26, OP_BGE   = 6'd27,
    OP_BLTU  = 6'd28, OP_BGEU  = 6'd29
  } openum_t;

  typedef logic [ROB_W-1:0] rob_index_t;

  // Operands of one dispatched op as held in S1
  typedef struct packed {
    openum_t         op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    rob_index_t      rob;
  } alu_req_t;
endpackage

module alu_unit
  import alu_unit_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clr_in,
  input  logic                  rs_to_alu_ready,
  input  openum_t               rs_to_alu_op,
  input  logic [XLEN-1:0]       rs_to_alu_rs1,
  input  logic [XLEN-1:0]       rs_to_alu_rs2,
  input  logic [XLEN-1:0]       rs_to_alu_imm,
  input  logic [XLEN-1:0]       rs_to_alu_PC,
  input  rob_index_t            rs_to_alu_rob_index,
  output logic                  alu_ready,
  output logic [XLEN-1:0]       alu_result,
  output rob_index_t            alu_rob_index,
  output logic                  alu_jump,
  output logic [XLEN-1:0]       alu_target_PC
);

  alu_req_t        s1_q, s1_d;
  logic            s1_valid_q, s1_valid_d;
  logic            alu_ready_q, alu_ready_d;
  logic [XLEN-1:0] alu_result_q, alu_result_d;
  rob_index_t      alu_rob_index_q, alu_rob_index_d;
  logic            alu_jump_q, alu_jump_d;
  logic [XLEN-1:0] alu_target_pc_q, alu_target_pc_d;

  logic            use_imm_c;
  logic [XLEN-1:0] op2_c;
  logic [4:0]      shamt_c;
  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] pc_plus_imm_c;
  logic            take_c;
  logic [XLEN-1:0] ex_result_c;
  logic            ex_jump_c;
  logic [XLEN-1:0] ex_target_c;

  // Immediate-form ops substitute imm for the second operand
  always_comb begin
    use_imm_c = 1'b0;
    case (s1_q.op)
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLLI, OP_SRLI, OP_SRAI,
      OP_SLTI, OP_SLTIU: use_imm_c = 1'b1;
      default:           use_imm_c = 1'b0;
    endcase
  end

  assign op2_c         = use_imm_c ? s1_q.imm : s1_q.rs2;
  assign shamt_c       = op2_c[4:0];
  assign pc_plus4_c    = s1_q.pc + 32'd4;
  assign pc_plus_imm_c = s1_q.pc + s1_q.imm;

  // Execute: result, jump decision and next PC of the op held in S1
  always_comb begin
    ex_result_c = '0;
    ex_jump_c   = 1'b0;
    ex_target_c = pc_plus4_c;
    take_c      = 1'b0;
    case (s1_q.op)
      OP_ADD, OP_ADDI:   ex_result_c = s1_q.rs1 + op2_c;
      OP_SUB:            ex_result_c = s1_q.rs1 - op2_c;
      OP_AND, OP_ANDI:   ex_result_c = s1_q.rs1 & op2_c;
      OP_OR,  OP_ORI:    ex_result_c = s1_q.rs1 | op2_c;
      OP_XOR, OP_XORI:   ex_result_c = s1_q.rs1 ^ op2_c;
      OP_SLL, OP_SLLI:   ex_result_c = s1_q.rs1 << shamt_c;
      OP_SRL, OP_SRLI:   ex_result_c = s1_q.rs1 >> shamt_c;
      OP_SRA, OP_SRAI:   ex_result_c = 32'($signed(s1_q.rs1) >>> shamt_c);
      OP_SLT, OP_SLTI:   ex_result_c = {31'd0, $signed(s1_q.rs1) < $signed(op2_c)};
      OP_SLTU, OP_SLTIU: ex_result_c = {31'd0, s1_q.rs1 < op2_c};
      OP_LUI:            ex_result_c = s1_q.imm;
      OP_AUIPC:          ex_result_c = pc_plus_imm_c;
      OP_JAL: begin
        ex_result_c = pc_plus4_c;
        ex_jump_c   = 1'b1;
        ex_target_c = pc_plus_imm_c;
      end
      OP_JALR: begin
        ex_result_c = pc_plus4_c;
        ex_jump_c   = 1'b1;
        ex_target_c = (s1_q.rs1 + s1_q.imm) & ~32'd1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (s1_q.op)
          OP_BEQ:  take_c = (s1_q.rs1 == s1_q.rs2);
          OP_BNE:  take_c = (s1_q.rs1 != s1_q.rs2);
          OP_BLT:  take_c = ($signed(s1_q.rs1) <  $signed(s1_q.rs2));
          OP_BGE:  take_c = ($signed(s1_q.rs1) >= $signed(s1_q.rs2));
          OP_BLTU: take_c = (s1_q.rs1 <  s1_q.rs2);
          default: take_c = (s1_q.rs1 >= s1_q.rs2);
        endcase
        ex_jump_c   = take_c;
        ex_target_c = take_c ? pc_plus_imm_c : pc_plus4_c;
      end
      // Unknown ops still broadcast (result 0) so the ROB entry retires
      default: ex_result_c = '0;
    endcase
  end

  // Next state: flush beats stall; stall holds everything
  always_comb begin
    s1_d            = s1_q;
    s1_valid_d      = s1_valid_q;
    alu_ready_d     = alu_ready_q;
    alu_result_d    = alu_result_q;
    alu_rob_index_d = alu_rob_index_q;
    alu_jump_d      = alu_jump_q;
    alu_target_pc_d = alu_target_pc_q;
    if (clr_in) begin
      s1_valid_d  = 1'b0;
      alu_ready_d = 1'b0;
    end else if (rdy_in) begin
      s1_valid_d = rs_to_alu_ready;
      if (rs_to_alu_ready) begin
        s1_d.op  = rs_to_alu_op;
        s1_d.rs1 = rs_to_alu_rs1;
        s1_d.rs2 = rs_to_alu_rs2;
        s1_d.imm = rs_to_alu_imm;
        s1_d.pc  = rs_to_alu_PC;
        s1_d.rob = rs_to_alu_rob_index;
      end
      alu_ready_d = s1_valid_q;
      // Data only moves with a valid op, so it holds while alu_ready is low
      if (s1_valid_q) begin
        alu_result_d    = ex_result_c;
        alu_rob_index_d = s1_q.rob;
        alu_jump_d      = ex_jump_c;
        alu_target_pc_d = ex_target_c;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_q            <= '0;
      s1_valid_q      <= 1'b0;
      alu_ready_q     <= 1'b0;
      alu_result_q    <= '0;
      alu_rob_index_q <= '0;
      alu_jump_q      <= 1'b0;
      alu_target_pc_q <= '0;
    end else begin
      s1_q            <= s1_d;
      s1_valid_q      <= s1_valid_d;
      alu_ready_q     <= alu_ready_d;
      alu_result_q    <= alu_result_d;
      alu_rob_index_q <= alu_rob_index_d;
      alu_jump_q      <= alu_jump_d;
      alu_target_pc_q <= alu_target_pc_d;
    end
  end

  assign alu_ready     = alu_ready_q;
  assign alu_result    = alu_result_q;
  assign alu_rob_index = alu_rob_index_q;
  assign alu_jump      = alu_jump_q;
  assign alu_target_PC = alu_target_pc_q;

endmodule
